// File: rtl/pixel_load_if.sv
// Bundle of command, RAM-read and pixel-delivery signals for pixel_load_sequencer.
//
// Handshake: a pixel transfers on a rising clk edge where pix_valid && pix_ready.
// Once pix_valid is high it stays high, and pix_data stays stable, until that
// transfer happens. pix_ready may change freely. The RAM side has no handshake.
// mem_rd_en is a one-cycle strobe, and mem_rdata returns the addressed byte on
// the following cycle.
interface pixel_load_if #(
  parameter int ADDR_W = 16,
  parameter int CNT_W  = 16
);
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [CNT_W-1:0]  count;
  logic              busy;
  logic              done;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_rdata;
  logic              pix_valid;
  logic [15:0]       pix_data;
  logic              pix_ready;

  // Environment side: issues commands, models the RAM and consumes pixels.
  modport master (
    output start, base_addr, count, mem_rdata, pix_ready,
    input  busy, done, mem_rd_en, mem_addr, pix_valid, pix_data
  );

  // Sequencer side.
  modport slave (
    input  start, base_addr, count, mem_rdata, pix_ready,
    output busy, done, mem_rd_en, mem_addr, pix_valid, pix_data
  );
endinterface

// File: rtl/pixel_load_sequencer.sv
// Burst pixel loader. It reads count bytes from the image RAM starting at
// base_addr and zero-extends each one to 16 bits. Each pixel is delivered through
// a 2-entry buffer, so the RAM read latency and consumer stalls never drop or
// repeat a pixel.
module pixel_load_sequencer #(
  parameter int ADDR_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic         clk,
  input  logic         reset,
  pixel_load_if.slave  bus,
  output logic [1:0]   dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  issued_q;
  logic [CNT_W-1:0]  delivered_q;
  logic              inflight_q;
  logic [1:0]        occ_q;
  logic [15:0]       ent0_q;
  logic [15:0]       ent1_q;

  logic              accept;
  logic              pop;
  logic              push;
  logic              issue;
  logic              last_pop;
  logic [2:0]        fill;
  logic [15:0]       din;

  // Datapath control terms shared by the FSM and the buffer.
  always_comb begin
    accept   = bus.start && (state != S_RUN);
    pop      = (occ_q != 2'd0) && bus.pix_ready;
    push     = inflight_q;
    // Buffer slots committed after this cycle. Pop implies occ >= 1, so the subtraction cannot wrap.
    fill     = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
    issue    = (state == S_RUN) && (issued_q < cnt_q) && (fill < 3'd2);
    last_pop = (state == S_RUN) && pop && (delivered_q == cnt_q - CNT_W'(1));
    din      = {8'h00, bus.mem_rdata};
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // FSM next-state logic. DONE accepts a new start just like IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: begin
        if (bus.start)             state_nxt = (bus.count == '0) ? S_DONE : S_RUN;
        else if (state == S_DONE)  state_nxt = S_IDLE;
      end
      S_RUN: begin
        if (last_pop) state_nxt = S_DONE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // FSM and datapath outputs.
  always_comb begin
    bus.busy      = (state == S_RUN);
    bus.done      = (state == S_DONE);
    bus.mem_rd_en = issue;
    bus.mem_addr  = addr_q;
    bus.pix_valid = (occ_q != 2'd0);
    bus.pix_data  = ent0_q;
    dbg_state     = state;
  end

  // Burst counters, read address and the in-flight flag for the pending RAM read.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q      <= '0;
      cnt_q       <= '0;
      issued_q    <= '0;
      delivered_q <= '0;
      inflight_q  <= 1'b0;
    end else begin
      inflight_q <= issue;
      if (accept) begin
        addr_q      <= bus.base_addr;
        cnt_q       <= bus.count;
        issued_q    <= '0;
        delivered_q <= '0;
      end else begin
        if (issue) begin
          addr_q   <= addr_q + ADDR_W'(1);
          issued_q <= issued_q + CNT_W'(1);
        end
        if (pop) delivered_q <= delivered_q + CNT_W'(1);
      end
    end
  end

  // Two-entry output buffer. ent0 is always the head entry presented on pix_data.
  always_ff @(posedge clk) begin
    if (reset) begin
      occ_q  <= 2'd0;
      ent0_q <= '0;
      ent1_q <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (occ_q == 2'd0) ent0_q <= din;
          else               ent1_q <= din;
          occ_q <= occ_q + 2'd1;
        end
        2'b01: begin
          ent0_q <= ent1_q;
          occ_q  <= occ_q - 2'd1;
        end
        2'b11: begin
          if (occ_q == 2'd1) begin
            ent0_q <= din;
          end else begin
            ent0_q <= ent1_q;
            ent1_q <= din;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_load_sequencer.sv
// Self-checking bench for pixel_load_sequencer. It runs directed burst scenarios,
// then randomized commands, consumer stalls and resets. The results are compared
// against a RAM-level behavioural model.
module tb_pixel_load_sequencer;
  localparam int ADDR_W = 16;
  localparam int CNT_W  = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] dbg_state;

  pixel_load_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus();

  pixel_load_sequencer #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / RAM ----------------
  always #5 clk = ~clk;

  logic [7:0] ram [0:65535];

  // Image RAM: one-cycle read latency.
  always @(posedge clk) begin
    if (bus.mem_rd_en) bus.mem_rdata <= ram[bus.mem_addr];
  end

  // ---------------- scoreboard / model ----------------
  int          checks = 0;
  int          failures = 0;
  logic [15:0] exp_q[$];
  logic [15:0] addr_q[$];
  bit          m_busy = 1'b0;
  bit          m_done = 1'b0;
  int          m_remaining = 0;
  int          m_reads = 0;
  int          m_pops = 0;
  bit          prev_stall = 1'b0;
  logic [15:0] prev_data = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process: each cycle, check the DUT against the model, then advance the model.
  always @(negedge clk) begin
    logic        pop_now;
    logic [15:0] e;
    logic [15:0] a;
    if (reset) begin
      exp_q.delete();
      addr_q.delete();
      m_busy = 1'b0;
      m_done = 1'b0;
      m_remaining = 0;
      m_reads = 0;
      m_pops = 0;
      prev_stall = 1'b0;
    end else begin
      chk("busy", bus.busy, m_busy);
      chk("done", bus.done, m_done);
      if (!m_busy) begin
        chk("idle_valid", bus.pix_valid, 0);
        chk("idle_read", bus.mem_rd_en, 0);
      end
      if (prev_stall) begin
        chk("hold_valid", bus.pix_valid, 1);
        chk("hold_data", bus.pix_data, prev_data);
      end
      pop_now = bus.pix_valid && bus.pix_ready;
      if (bus.mem_rd_en) begin
        if (addr_q.size() == 0) chk("extra_read", bus.mem_rd_en, 0);
        else begin
          e = addr_q.pop_front();
          chk("mem_addr", bus.mem_addr, e);
        end
        m_reads++;
      end
      if (pop_now) begin
        if (exp_q.size() == 0) chk("extra_pixel", bus.pix_valid, 0);
        else begin
          e = exp_q.pop_front();
          chk("pix_data", bus.pix_data, e);
        end
        m_pops++;
        m_remaining--;
      end
      if (m_busy) chk("outstanding_le2", (m_reads - m_pops) <= 2, 1);
      prev_stall = bus.pix_valid && !bus.pix_ready;
      prev_data  = bus.pix_data;
      // Model state for the next cycle.
      m_done = 1'b0;
      if (m_busy) begin
        if (pop_now && m_remaining == 0) begin
          m_busy = 1'b0;
          m_done = 1'b1;
        end
      end else if (bus.start) begin
        m_reads = 0;
        m_pops = 0;
        m_remaining = int'(bus.count);
        if (bus.count == '0) m_done = 1'b1;
        else begin
          m_busy = 1'b1;
          for (int i = 0; i < int'(bus.count); i++) begin
            a = bus.base_addr + 16'(i);
            addr_q.push_back(a);
            exp_q.push_back({8'h00, ram[a]});
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic start_burst(input logic [15:0] base, input logic [15:0] cnt);
    @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.base_addr = base;
    bus.count = cnt;
  endtask

  task automatic wait_idle(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      #2;
      if (!m_busy && !m_done) begin
        ok = 1'b1;
        break;
      end
    end
    chk(name, ok, 1);
  endtask

  // ---------------- stimulus ----------------
  logic [15:0] t1_pix [0:3];
  logic [15:0] t4_addr [0:2];
  logic [15:0] t4_seen [0:2];
  logic [15:0] t6_pix [0:1];

  initial begin
    int rd;
    int n;
    int dones;
    int pops;
    for (int i = 0; i < 65536; i++) ram[i] = 8'($urandom);
    bus.start = 1'b0;
    bus.base_addr = '0;
    bus.count = '0;
    bus.pix_ready = 1'b0;
    bus.mem_rdata = '0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_rd_en", bus.mem_rd_en, 0);
    chk("rst_addr", bus.mem_addr, 0);
    chk("rst_valid", bus.pix_valid, 0);
    chk("rst_data", bus.pix_data, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Test 1: basic burst with literal cycle expectations
    ram[16'h10] = 8'hA5; ram[16'h11] = 8'hFF; ram[16'h12] = 8'h00; ram[16'h13] = 8'h7E;
    t1_pix[0] = 16'h00A5; t1_pix[1] = 16'h00FF; t1_pix[2] = 16'h0000; t1_pix[3] = 16'h007E;
    bus.pix_ready = 1'b1;
    start_burst(16'h0010, 16'd4);
    for (int c = 1; c <= 7; c++) begin
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      @(negedge clk);
      chk("t1_rd_en", bus.mem_rd_en, (c >= 1 && c <= 4));
      if (c <= 4) chk("t1_addr", bus.mem_addr, 16'h0010 + 16'(c - 1));
      chk("t1_valid", bus.pix_valid, (c >= 3 && c <= 6));
      if (c >= 3 && c <= 6) chk("t1_pix", bus.pix_data, t1_pix[c - 3]);
      chk("t1_busy", bus.busy, (c <= 6));
      chk("t1_done", bus.done, (c == 7));
    end
    wait_idle("t1_idle");

    // Test 2: backpressure over cycles 3-8
    rd = 0;
    start_burst(16'h0010, 16'd4);
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      bus.pix_ready = !(c >= 3 && c <= 8);
      @(negedge clk);
      if (c <= 8 && bus.mem_rd_en) rd++;
      if (c >= 3 && c <= 8) begin
        chk("t2_valid", bus.pix_valid, 1);
        chk("t2_hold", bus.pix_data, 16'h00A5);
      end
    end
    chk("t2_reads_before_9", rd, 2);
    bus.pix_ready = 1'b1;
    wait_idle("t2_idle");

    // Test 3: zero-length burst
    start_burst(16'h0055, 16'd0);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    @(negedge clk);
    chk("t3_done", bus.done, 1);
    chk("t3_busy", bus.busy, 0);
    chk("t3_rd_en", bus.mem_rd_en, 0);
    @(negedge clk);
    chk("t3_done_end", bus.done, 0);
    chk("t3_busy_end", bus.busy, 0);
    wait_idle("t3_idle");

    // Test 4: address wrap
    t4_addr[0] = 16'hFFFE; t4_addr[1] = 16'hFFFF; t4_addr[2] = 16'h0000;
    n = 0; dones = 0; pops = 0;
    start_burst(16'hFFFE, 16'd3);
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      @(negedge clk);
      if (bus.mem_rd_en) begin
        if (n < 3) t4_seen[n] = bus.mem_addr;
        n++;
      end
      if (bus.done) dones++;
      if (bus.pix_valid && bus.pix_ready) pops++;
    end
    chk("t4_reads", n, 3);
    for (int i = 0; i < 3; i++) if (i < n) chk("t4_addr", t4_seen[i], t4_addr[i]);
    chk("t4_pixels", pops, 3);
    chk("t4_dones", dones, 1);
    wait_idle("t4_idle");

    // Test 5: start while busy is ignored; start in DONE is accepted
    start_burst(16'h0030, 16'd4);
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk);
      #1;
      bus.start = (c == 2) || (c == 7);
      bus.base_addr = (c == 2) ? 16'h0200 : 16'h0040;
      bus.count = (c == 2) ? 16'd5 : 16'd2;
      @(negedge clk);
      if (c <= 4) begin
        chk("t5_rd_en", bus.mem_rd_en, 1);
        chk("t5_addr", bus.mem_addr, 16'h0030 + 16'(c - 1));
      end
      if (c == 7) chk("t5_done", bus.done, 1);
      if (c == 8) begin
        chk("t5_next_rd_en", bus.mem_rd_en, 1);
        chk("t5_next_addr", bus.mem_addr, 16'h0040);
      end
    end
    bus.start = 1'b0;
    wait_idle("t5_idle");

    // Test 6: reset mid-burst, then a short burst
    start_burst(16'h0080, 16'd8);
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      reset = (c == 3);
      @(negedge clk);
      if (c == 4) begin
        chk("t6_busy", bus.busy, 0);
        chk("t6_done", bus.done, 0);
        chk("t6_rd_en", bus.mem_rd_en, 0);
        chk("t6_addr", bus.mem_addr, 0);
        chk("t6_valid", bus.pix_valid, 0);
        chk("t6_data", bus.pix_data, 0);
      end
    end
    ram[16'h0090] = 8'hC3; ram[16'h0091] = 8'h3C;
    t6_pix[0] = 16'h00C3; t6_pix[1] = 16'h003C;
    pops = 0;
    start_burst(16'h0090, 16'd2);
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      @(negedge clk);
      if (bus.pix_valid && bus.pix_ready) begin
        if (pops < 2) chk("t6_pix", bus.pix_data, t6_pix[pops]);
        pops++;
      end
    end
    chk("t6_pixels", pops, 2);
    wait_idle("t6_idle");

    // Random phase
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(posedge clk);
      #1;
      bus.start = ($urandom_range(0, 3) == 0);
      bus.base_addr = ($urandom_range(0, 4) == 0) ? 16'(16'hFFF8 + $urandom_range(0, 7))
                                                  : 16'($urandom);
      bus.count = 16'($urandom_range(0, 10));
      bus.pix_ready = ($urandom_range(0, 9) < 7);
      reset = ($urandom_range(0, 599) == 0);
    end
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    reset = 1'b0;
    bus.pix_ready = 1'b1;
    wait_idle("rand_drain");
    chk("rand_pix_queue_empty", exp_q.size(), 0);
    chk("rand_addr_queue_empty", addr_q.size(), 0);

    // Final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
